// File: rtl/c3aibadapt_sr_upd_pkg.sv
// -----------------------------------------------------------------------------
// c3aibadapt_sr_upd_pkg
// Shared definitions for the SR update bank:
//   - default parameter values (word width, synchroniser depth, counter width)
//   - parity-mode constants PAR_EVEN / PAR_ODD
//   - rst_val_mux: per-bit select between the two reset-value vectors
// -----------------------------------------------------------------------------
package c3aibadapt_sr_upd_pkg;

  localparam int DEF_DWIDTH      = 36;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ERR_CNT_W   = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // One bit of the run-time reset-value select; applied across the word by
  // the caller so it works for any DWIDTH.
  function automatic logic rst_val_mux(input logic sel, input logic v0, input logic v1);
    return sel ? v1 : v0;
  endfunction

endpackage

// File: rtl/c3aibadapt_sr_load_sync.sv
// -----------------------------------------------------------------------------
// c3aibadapt_sr_load_sync
// Re-times the asynchronous SR load strobe into the osc-clock domain through
// SYNC_STAGES flops, then detects its rising edge with one extra delay flop.
// Ports:
//   clk       osc clock
//   rst       synchronous active-high reset (clears the whole chain)
//   sr_load   asynchronous load strobe
//   load_rise one-cycle pulse on each synchronised rising edge of sr_load
// -----------------------------------------------------------------------------
module c3aibadapt_sr_load_sync #(
  parameter int SYNC_STAGES = c3aibadapt_sr_upd_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sr_load,
  output logic load_rise
);

  logic [SYNC_STAGES-1:0] s;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= '0;
      s_d <= 1'b0;
    end else begin
      s   <= {s[SYNC_STAGES-2:0], sr_load};
      s_d <= s[SYNC_STAGES-1];
    end
  end

  // A strobe held high produces only one pulse.
  assign load_rise = s[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/c3aibadapt_sr_update_bank.sv
// -----------------------------------------------------------------------------
// c3aibadapt_sr_update_bank
// Captures one DWIDTH SR word on a synchronised load strobe, parity-checks it
// and commits it to data_out unless frozen (then it waits as pending).
// Optional build macro: C3AIBADAPT_SR_UPD_CHG_DET_EN adds chg_det, a pulse
// coincident with upd_done carrying old data_out ^ committed word.
// Ports:
//   clk, rst      osc clock, synchronous active-high reset
//   rst_val_sel   selects RST_VAL1 (1) or RST_VAL0 (0) as data_out reset value
//   sr_load       asynchronous load strobe; sr_data/sr_par stable while high
//   sr_data       SR parallel word, sr_par its parity bit
//   freeze        defers commits while high
//   err_clr       clears par_err and err_cnt
//   data_out      committed word
//   upd_done      one-cycle pulse per commit
//   upd_pending   a parity-clean word is waiting on freeze
//   par_err       sticky parity-error flag
//   err_cnt       saturating count of rejected loads
//   chg_det       (macro only) changed-bit pulse on commit
// -----------------------------------------------------------------------------
module c3aibadapt_sr_update_bank #(
  parameter int                DWIDTH      = c3aibadapt_sr_upd_pkg::DEF_DWIDTH,
  parameter int                SYNC_STAGES = c3aibadapt_sr_upd_pkg::DEF_SYNC_STAGES,
  parameter logic [DWIDTH-1:0] RST_VAL0    = {DWIDTH{1'b0}},
  parameter logic [DWIDTH-1:0] RST_VAL1    = {DWIDTH{1'b1}},
  parameter logic              PAR_ODD     = c3aibadapt_sr_upd_pkg::PAR_EVEN,
  parameter int                ERR_CNT_W   = c3aibadapt_sr_upd_pkg::DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_val_sel,
  input  logic                 sr_load,
  input  logic [DWIDTH-1:0]    sr_data,
  input  logic                 sr_par,
  input  logic                 freeze,
  input  logic                 err_clr,
  output logic [DWIDTH-1:0]    data_out,
  output logic                 upd_done,
  output logic                 upd_pending,
  output logic                 par_err,
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
  output logic [DWIDTH-1:0]    chg_det,
`endif
  output logic [ERR_CNT_W-1:0] err_cnt
);

  import c3aibadapt_sr_upd_pkg::*;

  logic              load_rise;
  logic [DWIDTH-1:0] rst_val;
  logic [DWIDTH-1:0] shadow_p0;
  logic              shpar_p0;
  logic              chk_vld_p0;
  logic              par_ok_p1;
  logic              commit_p1;

  c3aibadapt_sr_load_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_load_sync (
    .clk      (clk),
    .rst      (rst),
    .sr_load  (sr_load),
    .load_rise(load_rise)
  );

  always_comb begin
    rst_val = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      rst_val[i] = rst_val_mux(rst_val_sel, RST_VAL0[i], RST_VAL1[i]);
    end
  end

  assign par_ok_p1 = ((^{shadow_p0, shpar_p0}) == PAR_ODD);

  // A fresh check commits directly when unfrozen; otherwise a pending word is
  // released as soon as freeze drops. The shadow always holds the latest word.
  assign commit_p1 = chk_vld_p0 ? (par_ok_p1 & ~freeze) : (upd_pending & ~freeze);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= rst_val;
      upd_done    <= 1'b0;
      upd_pending <= 1'b0;
      par_err     <= 1'b0;
      err_cnt     <= '0;
      shadow_p0   <= '0;
      shpar_p0    <= 1'b0;
      chk_vld_p0  <= 1'b0;
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
      chg_det     <= '0;
`endif
    end else begin
      upd_done <= 1'b0;
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
      chg_det  <= '0;
`endif

      // ---- S0: capture the word on the synchronised load edge ----
      chk_vld_p0 <= load_rise;
      if (load_rise) begin
        shadow_p0 <= sr_data;
        shpar_p0  <= sr_par;
      end

      if (err_clr) begin
        par_err <= 1'b0;
        err_cnt <= '0;
      end

      // ---- S1: parity check, then commit / defer / reject ----
      if (chk_vld_p0) begin
        if (!par_ok_p1) begin
          // A new error overrides a same-cycle clear.
          par_err     <= 1'b1;
          upd_pending <= 1'b0;
          if (err_clr) begin
            err_cnt <= ERR_CNT_W'(1);
          end else if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end else if (freeze) begin
          upd_pending <= 1'b1;
        end
      end

      if (commit_p1) begin
        data_out    <= shadow_p0;
        upd_done    <= 1'b1;
        upd_pending <= 1'b0;
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
        chg_det     <= data_out ^ shadow_p0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_c3aibadapt_sr_update_bank.sv
module tb_c3aibadapt_sr_update_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_val_sel = 1'b0;
  logic        sr_load = 1'b0;
  logic [35:0] sr_data = '0;
  logic        sr_par = 1'b0;
  logic        freeze = 1'b0;
  logic        err_clr = 1'b0;
  logic [35:0] data_out;
  logic        upd_done;
  logic        upd_pending;
  logic        par_err;
  logic [3:0]  err_cnt;
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
  logic [35:0] chg_det;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int base;

  localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;
  localparam logic [35:0] W0   = 36'h1_2345_6789;

  c3aibadapt_sr_update_bank dut (
    .clk        (clk),
    .rst        (rst),
    .rst_val_sel(rst_val_sel),
    .sr_load    (sr_load),
    .sr_data    (sr_data),
    .sr_par     (sr_par),
    .freeze     (freeze),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .upd_done   (upd_done),
    .upd_pending(upd_pending),
    .par_err    (par_err),
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
    .chg_det    (chg_det),
`endif
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd_done === 1'b1) done_cnt++;

  // Strobe held 3 cycles, then enough idle cycles for commit and sync flush.
  task automatic do_load(input logic [35:0] d, input logic p);
    sr_data = d; sr_par = p; sr_load = 1'b1;
    repeat (3) @(negedge clk);
    sr_load = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_val_sel = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data_out !== ONES) begin failures++; $display("FAIL rst_val1 data_out got=%h exp=%h", data_out, ONES); end
    checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL rst err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL rst par_err got=%b exp=0", par_err); end
    checks++; if (upd_done !== 1'b0 || upd_pending !== 1'b0) begin failures++; $display("FAIL rst done/pend got=%b%b exp=00", upd_done, upd_pending); end
    rst_val_sel = 1'b0;
    @(negedge clk);
    checks++; if (data_out !== 36'h0) begin failures++; $display("FAIL rst_val0 data_out got=%h exp=0", data_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_load;
    base = done_cnt;
    sr_data = W0; sr_par = 1'b1; sr_load = 1'b1;   // W0 has 15 ones
    repeat (3) @(negedge clk);                     // after edge 3
    checks++; if (data_out !== 36'h0 || upd_done !== 1'b0) begin failures++; $display("FAIL early_commit data_out=%h done=%b exp=0/0", data_out, upd_done); end
    sr_load = 1'b0;
    @(negedge clk);                                // after edge 4
    checks++; if (data_out !== W0) begin failures++; $display("FAIL good_load data_out got=%h exp=%h", data_out, W0); end
    checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL good_load upd_done got=%b exp=1", upd_done); end
    @(negedge clk);
    checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL good_load pulse_len upd_done got=%b exp=0", upd_done); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL good_load done_count got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_parity_err;
    for (int i = 0; i < 3; i++) do_load(36'hC, 1'b1);  // 36'hC needs par 0
    checks++; if (data_out !== W0) begin failures++; $display("FAIL par_err data_out got=%h exp=%h", data_out, W0); end
    checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL par_err flag got=%b exp=1", par_err); end
    checks++; if (err_cnt !== 4'd3) begin failures++; $display("FAIL par_err cnt3 got=%0d exp=3", err_cnt); end
    for (int i = 0; i < 17; i++) do_load(36'h7, 1'b0);  // 36'h7 needs par 1
    checks++; if (err_cnt !== 4'd15) begin failures++; $display("FAIL par_err saturate got=%0d exp=15", err_cnt); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (par_err !== 1'b0 || err_cnt !== 4'd0) begin failures++; $display("FAIL err_clr got=%b/%0d exp=0/0", par_err, err_cnt); end
    checks++; if (data_out !== W0) begin failures++; $display("FAIL par_err final data_out got=%h exp=%h", data_out, W0); end
  endtask

  task automatic test_freeze;
    base = done_cnt;
    freeze = 1'b1;
    do_load(36'hA, 1'b0);
    checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL freeze pending got=%b exp=1", upd_pending); end
    checks++; if (data_out !== W0) begin failures++; $display("FAIL freeze held got=%h exp=%h", data_out, W0); end
    do_load(36'hB, 1'b1);
    checks++; if (upd_pending !== 1'b1 || data_out !== W0) begin failures++; $display("FAIL freeze second pend=%b data_out=%h exp=1/%h", upd_pending, data_out, W0); end
    checks++; if (done_cnt !== base) begin failures++; $display("FAIL freeze no_done got=%0d exp=%0d", done_cnt, base); end
    freeze = 1'b0;
    @(negedge clk);
    checks++; if (data_out !== 36'hB) begin failures++; $display("FAIL release data_out got=%h exp=b", data_out); end
    checks++; if (upd_done !== 1'b1 || upd_pending !== 1'b0) begin failures++; $display("FAIL release done/pend got=%b%b exp=10", upd_done, upd_pending); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL release done_count got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_simultaneous;
    do_load(36'hC, 1'b1);
    checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL simul pre cnt got=%0d exp=1", err_cnt); end
    sr_data = 36'hC; sr_par = 1'b1; sr_load = 1'b1;
    repeat (3) @(negedge clk);
    err_clr = 1'b1; sr_load = 1'b0;                // lands on the failing check
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (par_err !== 1'b1 || err_cnt !== 4'd1) begin failures++; $display("FAIL simul err_wins got=%b/%0d exp=1/1", par_err, err_cnt); end
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (par_err !== 1'b0 || err_cnt !== 4'd0) begin failures++; $display("FAIL simul clr got=%b/%0d exp=0/0", par_err, err_cnt); end
  endtask

  task automatic test_reset_pending;
    freeze = 1'b1;
    do_load(36'h5, 1'b0);
    checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL rstpend pending got=%b exp=1", upd_pending); end
    base = done_cnt;
    rst_val_sel = 1'b1; rst = 1'b1; freeze = 1'b0;
    @(negedge clk);
    checks++; if (upd_pending !== 1'b0 || upd_done !== 1'b0) begin failures++; $display("FAIL rstpend pend/done got=%b%b exp=00", upd_pending, upd_done); end
    checks++; if (data_out !== ONES) begin failures++; $display("FAIL rstpend data_out got=%h exp=%h", data_out, ONES); end
    rst = 1'b0; rst_val_sel = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== base) begin failures++; $display("FAIL rstpend late_done got=%0d exp=%0d", done_cnt, base); end
    checks++; if (data_out !== ONES) begin failures++; $display("FAIL rst_val_sel_static data_out got=%h exp=%h", data_out, ONES); end
  endtask

`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
  task automatic test_chg_det;
    rst_val_sel = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (chg_det !== 36'h0 || data_out !== 36'h0) begin failures++; $display("FAIL chg rst got=%h/%h exp=0/0", chg_det, data_out); end
    for (int k = 0; k < 2; k++) begin
      sr_data = 36'h5; sr_par = 1'b0; sr_load = 1'b1;
      repeat (3) @(negedge clk);
      sr_load = 1'b0;
      @(negedge clk);
      checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL chg done%0d got=%b exp=1", k, upd_done); end
      checks++; if (chg_det !== (k == 0 ? 36'h5 : 36'h0)) begin failures++; $display("FAIL chg val%0d got=%h exp=%h", k, chg_det, (k == 0 ? 36'h5 : 36'h0)); end
      @(negedge clk);
      checks++; if (chg_det !== 36'h0) begin failures++; $display("FAIL chg clear%0d got=%h exp=0", k, chg_det); end
      repeat (4) @(negedge clk);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_good_load();
    test_parity_err();
    test_freeze();
    test_simultaneous();
    test_reset_pending();
`ifdef C3AIBADAPT_SR_UPD_CHG_DET_EN
    test_chg_det();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
